dbc_port_sm_multi: RTL and testbench
====================================

Name: dbc_port_sm_multi

Overview:
- Parametrised multi-port successor of the single-port DbC port state machine.
- Runs one independent DbC port state machine per port. Each machine keeps sticky change bits (CSC, PLC, PRC, CEC) and a PED status bit.
- A round-robin arbiter turns change-bit set events into a valid/ready event stream toward the DbC event ring logic.
- Adds features the single-port block lacks: N ports, a reset-timeout counter, write-1-to-clear change bits, and an event handshake.

Parameters:
NUM_PORTS, 2, number of port channels (1..8)
TMR_W, 8, width of the per-port reset timeout counter
RESET_TIMEOUT, 100, RESETTING cycles before forced ERROR (must be < 2^TMR_W)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
dce  in  NUM_PORTS  DbC enable per port
ccs  in  NUM_PORTS  current connect status per port
pr  in  NUM_PORTS  port reset in progress per port
link_ok  in  NUM_PORTS  link trained/U0 per port
cfg_err  in  NUM_PORTS  configuration error pulse per port
chg_clr  in  4*NUM_PORTS  W1C per port, bits [4p+3:4p] = {CEC,PRC,PLC,CSC}
state  out  3*NUM_PORTS  per-port state code
ped  out  NUM_PORTS  port enabled
chg  out  4*NUM_PORTS  sticky change bits, same packing as chg_clr
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_port  out  3  port index of event
evt_bits  out  4  change-bit snapshot {CEC,PRC,PLC,CSC}

Behaviour:
- Reset: all state=OFF(0), ped=0, chg=0, timers=0, pending=0, evt_valid=0, evt_port=0, evt_bits=0, RR pointer=0.
- All outputs are registered. An input sampled at edge k appears in state/ped/chg after edge k.
- State codes: OFF=0, DISCONNECTED=1, RESETTING=2, ENABLED=3, ERROR=4. Codes 5-7 are illegal and go to OFF.
- Transitions are evaluated per port in this priority order:
  - 1) dce=0: go to OFF from any state; ped=0; change bits held; no change bits set.
  - 2) OFF and dce=1: go to DISCONNECTED.
  - 3) ccs=0 in RESETTING, ENABLED or ERROR: go to DISCONNECTED; set CSC; ped=0.
  - 4) DISCONNECTED and ccs=1: go to RESETTING; set CSC; timer=0.
  - 5) RESETTING:
    - pr=0 and link_ok=1: go to ENABLED; set PRC; ped=1.
    - Otherwise, if timer==RESET_TIMEOUT-1: go to ERROR; set CEC.
    - Otherwise: timer+1.
  - 6) ENABLED:
    - cfg_err=1: go to ERROR; set CEC; ped=0.
    - Otherwise, pr=1: go to RESETTING; set PRC; ped=0; timer=0.
    - Otherwise, link_ok=0: set PLC; stay ENABLED.
  - 7) ERROR: stays until rule 1 or rule 3 applies.
- PLC is edge-based: it is set only on the cycle link_ok transitions 1->0 in ENABLED, not every cycle it is low.
- Change bits are sticky until cleared by chg_clr. If set and clear hit the same bit in the same cycle, set wins.
- Pending flag:
  - Set for port p when any chg bit of p goes 0->1.
  - Clear-and-set in the same cycle results in pending set.
- Arbiter:
  - When evt_valid=0 and any port is pending, grant the first pending port at or after the RR pointer (wrapping).
  - On the next edge: evt_valid=1, evt_port=p, evt_bits=chg[p] snapshot, pending[p] cleared.
  - evt_port and evt_bits are held stable while evt_valid=1 and evt_ready=0.
  - Handshake on evt_valid&evt_ready:
    - evt_valid drops the next cycle unless another port is pending (back-to-back grant allowed).
    - RR pointer becomes p+1 mod NUM_PORTS.
  - New changes on the granted port during valid re-set its pending flag and produce a later event.
- Latency: input event to evt_valid=1 is 2 cycles minimum when the arbiter is idle.
- Reset asserted mid-operation forces the full reset values on the next edge, including dropping evt_valid without a handshake.

Test Plan:
- Reset, then dce=1, ccs=1 on port0 -> state0: 0->1->2, CSC set, evt_valid=1, evt_port=0, evt_bits=4'b0001.
- Continuing: pr=0, link_ok=1 -> state0=3, ped0=1, PRC set, second event evt_bits=4'b0101 after chg_clr of CSC is withheld.
- Port1 in RESETTING with link_ok=0 for 100 cycles -> state1=4 on cycle 100, CEC set, ped1=0, event evt_port=1, evt_bits[3]=1.
- Ports 0 and 1 set CSC in the same cycle, evt_ready=1 -> events come out as port0 then port1 on consecutive cycles. Repeat with pointer=1 -> port1 first.
- Hold evt_ready=0 for 10 cycles while port0 gains PLC -> evt_bits unchanged during the stall; a second port0 event follows the handshake.
- Port0 in ENABLED, drop dce -> state0=0 next cycle, ped0=0, chg bits held. chg_clr=4'b1111 together with a simultaneous CSC set -> CSC remains 1.

Source files
------------

// File: rtl/dbc_port_sm_multi.sv
// rtl/dbc_port_sm_multi.sv - per-port DbC port state machines with a round-robin change-event arbiter
module dbc_port_sm_multi #(
    parameter int NUM_PORTS     = 2,
    parameter int TMR_W         = 8,
    parameter int RESET_TIMEOUT = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   dce,
    input  logic [NUM_PORTS-1:0]   ccs,
    input  logic [NUM_PORTS-1:0]   pr,
    input  logic [NUM_PORTS-1:0]   link_ok,
    input  logic [NUM_PORTS-1:0]   cfg_err,
    input  logic [4*NUM_PORTS-1:0] chg_clr,
    output logic [3*NUM_PORTS-1:0] state,
    output logic [NUM_PORTS-1:0]   ped,
    output logic [4*NUM_PORTS-1:0] chg,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [2:0]             evt_port,
    output logic [3:0]             evt_bits
);

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_DISC = 3'd1;
    localparam logic [2:0] ST_RST  = 3'd2;
    localparam logic [2:0] ST_EN   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(RESET_TIMEOUT - 1);

    logic [2:0]       st_q   [NUM_PORTS];
    logic [2:0]       st_d   [NUM_PORTS];
    logic [TMR_W-1:0] tmr_q  [NUM_PORTS];
    logic [TMR_W-1:0] tmr_d  [NUM_PORTS];
    logic [3:0]       chg_q  [NUM_PORTS];
    logic [3:0]       chg_d  [NUM_PORTS];
    logic [3:0]       set_b  [NUM_PORTS];

    logic [NUM_PORTS-1:0] ped_q, ped_d;
    logic [NUM_PORTS-1:0] link_q;
    logic [NUM_PORTS-1:0] pend_q, pend_d, pend_set;

    logic       evt_valid_q;
    logic [2:0] evt_port_q;
    logic [3:0] evt_bits_q;
    logic [2:0] ptr_q;
    logic [2:0] ptr_inc;
    logic [2:0] start_ptr;
    logic       hs;
    logic       gnt_found;
    logic [2:0] gnt_idx;
    logic [3:0] gnt_bits;
    int         cand;

    // Change bits are {CEC,PRC,PLC,CSC}; set_b collects this cycle's set events.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            st_d[p]  = st_q[p];
            tmr_d[p] = tmr_q[p];
            ped_d[p] = ped_q[p];
            set_b[p] = 4'b0000;
            if (!dce[p]) begin
                st_d[p]  = ST_OFF;
                ped_d[p] = 1'b0;
            end else begin
                case (st_q[p])
                    ST_OFF: st_d[p] = ST_DISC;
                    ST_DISC: begin
                        if (ccs[p]) begin
                            st_d[p]     = ST_RST;
                            set_b[p][0] = 1'b1;
                            tmr_d[p]    = '0;
                        end
                    end
                    ST_RST: begin
                        if (!ccs[p]) begin
                            st_d[p]     = ST_DISC;
                            set_b[p][0] = 1'b1;
                            ped_d[p]    = 1'b0;
                        end else if (!pr[p] && link_ok[p]) begin
                            st_d[p]     = ST_EN;
                            set_b[p][2] = 1'b1;
                            ped_d[p]    = 1'b1;
                        end else if (tmr_q[p] == TMO_LAST) begin
                            st_d[p]     = ST_ERR;
                            set_b[p][3] = 1'b1;
                        end else begin
                            tmr_d[p] = tmr_q[p] + 1'b1;
                        end
                    end
                    ST_EN: begin
                        if (!ccs[p]) begin
                            st_d[p]     = ST_DISC;
                            set_b[p][0] = 1'b1;
                            ped_d[p]    = 1'b0;
                        end else if (cfg_err[p]) begin
                            st_d[p]     = ST_ERR;
                            set_b[p][3] = 1'b1;
                            ped_d[p]    = 1'b0;
                        end else if (pr[p]) begin
                            st_d[p]     = ST_RST;
                            set_b[p][2] = 1'b1;
                            ped_d[p]    = 1'b0;
                            tmr_d[p]    = '0;
                        end else if (!link_ok[p] && link_q[p]) begin
                            set_b[p][1] = 1'b1;
                        end
                    end
                    ST_ERR: begin
                        if (!ccs[p]) begin
                            st_d[p]     = ST_DISC;
                            set_b[p][0] = 1'b1;
                            ped_d[p]    = 1'b0;
                        end
                    end
                    default: begin
                        st_d[p]  = ST_OFF;
                        ped_d[p] = 1'b0;
                    end
                endcase
            end
            chg_d[p] = (chg_q[p] & ~chg_clr[4*p +: 4]) | set_b[p];
            // A set that lands on a bit being cleared still counts as a new change.
            pend_set[p] = |(set_b[p] & (~chg_q[p] | chg_clr[4*p +: 4]));
        end
    end

    assign hs        = evt_valid_q & evt_ready;
    assign ptr_inc   = (int'(evt_port_q) == NUM_PORTS - 1) ? 3'd0 : evt_port_q + 3'd1;
    assign start_ptr = hs ? ptr_inc : ptr_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        gnt_bits  = 4'd0;
        cand      = 0;
        if (!evt_valid_q || evt_ready) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand = int'(start_ptr) + i;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (!gnt_found && pend_q[j] && cand == j) begin
                        gnt_found = 1'b1;
                        gnt_idx   = 3'(j);
                        gnt_bits  = chg_q[j];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pend_d[p] = (pend_q[p] & ~(gnt_found && int'(gnt_idx) == p)) | pend_set[p];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                st_q[p]  <= ST_OFF;
                tmr_q[p] <= '0;
                chg_q[p] <= 4'b0000;
            end
            ped_q       <= '0;
            link_q      <= '0;
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_port_q  <= 3'd0;
            evt_bits_q  <= 4'd0;
            ptr_q       <= 3'd0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                st_q[p]  <= st_d[p];
                tmr_q[p] <= tmr_d[p];
                chg_q[p] <= chg_d[p];
            end
            ped_q  <= ped_d;
            link_q <= link_ok;
            pend_q <= pend_d;
            if (hs) begin
                ptr_q <= ptr_inc;
            end
            if (!evt_valid_q || evt_ready) begin
                evt_valid_q <= gnt_found;
                if (gnt_found) begin
                    evt_port_q <= gnt_idx;
                    evt_bits_q <= gnt_bits;
                end
            end
        end
    end

    always_comb begin
        state = '0;
        chg   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state[3*p +: 3] = st_q[p];
            chg[4*p +: 4]   = chg_q[p];
        end
    end

    assign ped       = ped_q;
    assign evt_valid = evt_valid_q;
    assign evt_port  = evt_port_q;
    assign evt_bits  = evt_bits_q;

endmodule

// File: tb/tb_dbc_port_sm_multi.sv
// tb/tb_dbc_port_sm_multi.sv - randomized scoreboard bench for dbc_port_sm_multi
module tb_dbc_port_sm_multi;

    localparam int NP = 3;
    localparam int RT = 100;

    logic            clock;
    logic            reset;
    logic [NP-1:0]   dce, ccs, pr, link_ok, cfg_err;
    logic [4*NP-1:0] chg_clr;
    logic [3*NP-1:0] state;
    logic [NP-1:0]   ped;
    logic [4*NP-1:0] chg;
    logic            evt_valid;
    logic            evt_ready;
    logic [2:0]      evt_port;
    logic [3:0]      evt_bits;

    int checks = 0;
    int errors = 0;

    dbc_port_sm_multi #(.NUM_PORTS(NP), .TMR_W(8), .RESET_TIMEOUT(RT)) dut (
        .clock(clock), .reset(reset), .dce(dce), .ccs(ccs), .pr(pr),
        .link_ok(link_ok), .cfg_err(cfg_err), .chg_clr(chg_clr),
        .state(state), .ped(ped), .chg(chg),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_port(evt_port), .evt_bits(evt_bits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: 0 OFF, 1 DISCONNECTED, 2 RESETTING, 3 ENABLED, 4 ERROR
    int       m_state [NP];
    bit       m_ped   [NP];
    bit [3:0] m_chg   [NP];
    int       m_tmr   [NP];
    bit       m_lprev [NP];
    bit       m_pend  [NP];
    bit       m_valid;
    int       m_port;
    bit [3:0] m_bits;
    int       m_ptr;
    bit       m_rst_flag;
    bit [6:0] exp_q [$];

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_state[p] = 0; m_ped[p] = 0; m_chg[p] = 0;
            m_tmr[p] = 0; m_lprev[p] = 0; m_pend[p] = 0;
        end
        m_valid = 0; m_port = 0; m_bits = 0; m_ptr = 0; m_rst_flag = 1;
        exp_q.delete();
    endtask

    task automatic model_port(input int p, output bit [3:0] sb);
        int s;
        s  = m_state[p];
        sb = 4'b0000;
        if (!dce[p]) begin
            m_state[p] = 0; m_ped[p] = 0;
        end else if (s == 0) begin
            m_state[p] = 1;
        end else if (!ccs[p] && s >= 2) begin
            m_state[p] = 1; sb[0] = 1; m_ped[p] = 0;
        end else if (s == 1) begin
            if (ccs[p]) begin m_state[p] = 2; sb[0] = 1; m_tmr[p] = 0; end
        end else if (s == 2) begin
            if (!pr[p] && link_ok[p]) begin m_state[p] = 3; sb[2] = 1; m_ped[p] = 1; end
            else if (m_tmr[p] == RT - 1) begin m_state[p] = 4; sb[3] = 1; end
            else m_tmr[p]++;
        end else if (s == 3) begin
            if (cfg_err[p]) begin m_state[p] = 4; sb[3] = 1; m_ped[p] = 0; end
            else if (pr[p]) begin m_state[p] = 2; sb[2] = 1; m_ped[p] = 0; m_tmr[p] = 0; end
            else if (!link_ok[p] && m_lprev[p]) sb[1] = 1;
        end
    endtask

    task automatic model_step();
        int       g;
        int       start;
        bit [3:0] snap;
        bit [3:0] sb;
        bit [3:0] clr;
        bit       newchg;
        g = -1;
        snap = 0;
        if (!m_valid || evt_ready) begin
            start = (m_valid && evt_ready) ? (m_port + 1) % NP : m_ptr;
            for (int k = 0; k < NP; k++) begin
                if (g < 0 && m_pend[(start + k) % NP]) g = (start + k) % NP;
            end
            if (g >= 0) snap = m_chg[g];
        end
        if (m_valid && evt_ready) m_ptr = (m_port + 1) % NP;
        for (int p = 0; p < NP; p++) begin
            model_port(p, sb);
            clr = chg_clr[4*p +: 4];
            newchg = 0;
            for (int b = 0; b < 4; b++) begin
                if (sb[b] && (!m_chg[p][b] || clr[b])) newchg = 1;
            end
            m_chg[p]   = (m_chg[p] & ~clr) | sb;
            m_pend[p]  = (m_pend[p] && g != p) || newchg;
            m_lprev[p] = link_ok[p];
        end
        if (!m_valid || evt_ready) begin
            if (g >= 0) begin
                m_valid = 1; m_port = g; m_bits = snap;
                exp_q.push_back({3'(g), snap});
            end else begin
                m_valid = 0;
            end
        end
        m_rst_flag = 0;
    endtask

    task automatic check_all();
        logic [3*NP-1:0] es;
        logic [NP-1:0]   ep;
        logic [4*NP-1:0] ec;
        for (int p = 0; p < NP; p++) begin
            es[3*p +: 3] = 3'(m_state[p]);
            ep[p]        = m_ped[p];
            ec[4*p +: 4] = m_chg[p];
        end
        expect_eq("state", 32'(state), 32'(es));
        expect_eq("ped", 32'(ped), 32'(ep));
        expect_eq("chg", 32'(chg), 32'(ec));
        expect_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid || m_rst_flag) begin
            expect_eq("evt_port", 32'(evt_port), 32'(m_port));
            expect_eq("evt_bits", 32'(evt_bits), 32'(m_bits));
        end
    endtask

    task automatic cycle();
        if (reset) model_reset();
        else model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    // Scoreboard monitor: every presented event must match the front of the expected queue.
    always @(negedge clock) begin
        if (!reset && evt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_evt: port=%0d bits=%b, none expected", evt_port, evt_bits);
            end else begin
                expect_eq("sb_evt_port", 32'(evt_port), 32'(exp_q[0][6:4]));
                expect_eq("sb_evt_bits", 32'(evt_bits), 32'(exp_q[0][3:0]));
                if (evt_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1; dce = 0; ccs = 0; pr = 0; link_ok = 0; cfg_err = 0;
        chg_clr = '0; evt_ready = 0;
        cycle(); cycle();
        expect_eq("rst_state", 32'(state), 32'd0);
        expect_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
        reset = 0;

        // Port0 connect, first event, then enable with a stalled consumer
        dce = 3'b001; ccs = 3'b001;
        cycle();
        cycle();
        expect_eq("p0_resetting", 32'(state[2:0]), 32'd2);
        expect_eq("p0_csc", 32'(chg[3:0]), 32'b0001);
        cycle();
        expect_eq("ev1_valid", 32'(evt_valid), 32'd1);
        expect_eq("ev1_bits", 32'(evt_bits), 32'b0001);
        link_ok = 3'b001;
        cycle();
        expect_eq("p0_enabled", 32'(state[2:0]), 32'd3);
        expect_eq("p0_ped", 32'(ped[0]), 32'd1);
        expect_eq("ev1_held", 32'(evt_bits), 32'b0001);
        evt_ready = 1;
        cycle();
        expect_eq("ev2_bits", 32'(evt_bits), 32'b0101);
        cycle();
        expect_eq("ev2_drop", 32'(evt_valid), 32'd0);

        // Port1 reset timeout
        dce = 3'b011; ccs = 3'b011;
        cycle(); cycle();
        repeat (99) cycle();
        expect_eq("p1_pre_timeout", 32'(state[5:3]), 32'd2);
        cycle();
        expect_eq("p1_error", 32'(state[5:3]), 32'd4);
        expect_eq("p1_cec", 32'(chg[7]), 32'd1);
        expect_eq("p1_ped", 32'(ped[1]), 32'd0);
        cycle();
        expect_eq("ev_cec_port", 32'(evt_port), 32'd1);
        expect_eq("ev_cec_bit", 32'(evt_bits[3]), 32'd1);
        cycle();

        // Simultaneous CSC on both ports, pointer at 2 then at 1
        chg_clr = '1; cycle(); chg_clr = '0;
        ccs = 3'b000; link_ok = 3'b000;
        cycle(); cycle();
        expect_eq("rr_a_first", 32'(evt_port), 32'd0);
        cycle();
        expect_eq("rr_a_second", 32'(evt_port), 32'd1);
        cycle();
        chg_clr = '1; cycle(); chg_clr = '0;
        ccs = 3'b001;
        cycle(); cycle(); cycle();
        ccs = 3'b010; chg_clr = '1;
        cycle();
        chg_clr = '0;
        cycle();
        expect_eq("rr_b_first", 32'(evt_port), 32'd1);
        cycle();
        expect_eq("rr_b_second", 32'(evt_port), 32'd0);
        cycle();

        // Stall while port0 gains PRC and PLC
        ccs = 3'b000; link_ok = 3'b000; chg_clr = '1;
        cycle(); chg_clr = '0;
        cycle(); cycle(); cycle();
        evt_ready = 0; ccs = 3'b001;
        cycle(); cycle();
        expect_eq("stall_bits_start", 32'(evt_bits), 32'b0001);
        link_ok = 3'b001; cycle();
        link_ok = 3'b000; cycle();
        repeat (8) begin
            cycle();
            expect_eq("stall_bits_hold", 32'(evt_bits), 32'b0001);
        end
        evt_ready = 1;
        cycle();
        expect_eq("post_stall_bits", 32'(evt_bits), 32'b0111);
        cycle();

        // dce drop holds change bits; clear collides with a CSC set
        dce = 3'b000;
        cycle();
        expect_eq("dce_off_state", 32'(state[2:0]), 32'd0);
        expect_eq("dce_off_chg_held", 32'(chg[3:0]), 32'b0111);
        dce = 3'b001; ccs = 3'b001;
        cycle();
        chg_clr = 12'h00F;
        cycle();
        expect_eq("clr_vs_set", 32'(chg[3:0]), 32'b0001);
        chg_clr = '0;
        cycle(); cycle(); cycle();

        // Randomized traffic
        dce = '1; ccs = '1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int p = 0; p < NP; p++) begin
                if (dce[p]) dce[p] = ($urandom_range(0, 99) >= 1);
                else dce[p] = ($urandom_range(0, 99) < 10);
                if (ccs[p]) ccs[p] = ($urandom_range(0, 99) >= 3);
                else ccs[p] = ($urandom_range(0, 99) < 20);
                if (pr[p]) pr[p] = ($urandom_range(0, 99) >= 30);
                else pr[p] = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 99) < 8) link_ok[p] = ~link_ok[p];
                cfg_err[p] = ($urandom_range(0, 99) < 2);
                for (int b = 0; b < 4; b++) chg_clr[4*p + b] = ($urandom_range(0, 99) < 6);
            end
            evt_ready = ($urandom_range(0, 99) < 65);
            cycle();
        end

        // Reset in the middle of a stalled event
        reset = 0; cfg_err = '0; chg_clr = '0; pr = '0; evt_ready = 0;
        dce = 3'b000; cycle();
        dce = 3'b001; ccs = 3'b001;
        cycle(); cycle(); cycle();
        reset = 1;
        cycle();
        expect_eq("midrst_valid", 32'(evt_valid), 32'd0);
        expect_eq("midrst_chg", 32'(chg), 32'd0);
        expect_eq("midrst_state", 32'(state), 32'd0);
        reset = 0; evt_ready = 1;
        repeat (5) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
